// File: rtl/exe_issue_ctrl_if.sv
// rtl/exe_issue_ctrl_if.sv - ID issue, EXE slot, status and data-memory handshake bundle for exe_issue_ctrl
interface exe_issue_ctrl_if #(
    parameter int unsigned STALL_CNT_W = 16
);
    logic                   id_valid;
    logic                   id_ready;
    logic [3:0]             id_exe_cmd;
    logic                   id_mem_r_en;
    logic                   id_mem_w_en;
    logic                   id_s;
    logic                   id_b;

    logic                   exe_valid;
    logic [3:0]             exe_cmd;
    logic                   exe_mem_r_en;
    logic                   exe_mem_w_en;

    logic [3:0]             alu_status;
    logic [3:0]             sr;

    logic                   mem_req;
    logic                   mem_ready;

    logic                   commit;
    logic                   flush;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Pipeline side: ID stage, ALU and data memory.
    modport master (
        output id_valid, id_exe_cmd, id_mem_r_en, id_mem_w_en, id_s, id_b,
        output alu_status, mem_ready,
        input  id_ready, exe_valid, exe_cmd, exe_mem_r_en, exe_mem_w_en,
        input  sr, mem_req, commit, flush, stall_cnt
    );

    modport slave (
        input  id_valid, id_exe_cmd, id_mem_r_en, id_mem_w_en, id_s, id_b,
        input  alu_status, mem_ready,
        output id_ready, exe_valid, exe_cmd, exe_mem_r_en, exe_mem_w_en,
        output sr, mem_req, commit, flush, stall_cnt
    );
endinterface

// File: rtl/exe_issue_ctrl.sv
// rtl/exe_issue_ctrl.sv - EXE-stage issue controller: one-entry slot, memory stall, branch flush, NZCV, stall counter
module exe_issue_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned STALL_CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    exe_issue_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_e                 state_q;
    logic [3:0]             flush_cnt_q;

    logic                   exe_valid_q,    exe_valid_d;
    logic [3:0]             exe_cmd_q,      exe_cmd_d;
    logic                   exe_mem_r_en_q, exe_mem_r_en_d;
    logic                   exe_mem_w_en_q, exe_mem_w_en_d;
    logic                   slot_s_q,       slot_s_d;
    logic                   slot_b_q,       slot_b_d;
    logic [3:0]             sr_q,           sr_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q,    stall_cnt_d;

    logic slot_mem;
    logic in_flush;
    logic commit;
    logic flush;
    logic id_ready;
    logic issue;

    assign slot_mem = exe_mem_r_en_q | exe_mem_w_en_q;
    assign in_flush = (state_q == ST_FLUSH);
    assign commit   = exe_valid_q & ~in_flush & (~slot_mem | bus.mem_ready);
    assign flush    = commit & slot_b_q;
    // A committing slot frees itself in the same cycle, so ID can issue back-to-back.
    assign id_ready = ~in_flush & ~flush & (~exe_valid_q | commit);
    assign issue    = bus.id_valid & id_ready;

    assign bus.id_ready     = id_ready;
    assign bus.commit       = commit;
    assign bus.flush        = flush;
    assign bus.mem_req      = exe_valid_q & slot_mem & ~in_flush;
    assign bus.exe_valid    = exe_valid_q;
    assign bus.exe_cmd      = exe_cmd_q;
    assign bus.exe_mem_r_en = exe_mem_r_en_q;
    assign bus.exe_mem_w_en = exe_mem_w_en_q;
    assign bus.sr           = sr_q;
    assign bus.stall_cnt    = stall_cnt_q;

    always_comb begin
        exe_valid_d    = exe_valid_q;
        exe_cmd_d      = exe_cmd_q;
        exe_mem_r_en_d = exe_mem_r_en_q;
        exe_mem_w_en_d = exe_mem_w_en_q;
        slot_s_d       = slot_s_q;
        slot_b_d       = slot_b_q;
        if (issue) begin
            exe_valid_d    = 1'b1;
            exe_cmd_d      = bus.id_exe_cmd;
            exe_mem_r_en_d = bus.id_mem_r_en;
            exe_mem_w_en_d = bus.id_mem_w_en;
            slot_s_d       = bus.id_s;
            slot_b_d       = bus.id_b;
        end else if (commit | in_flush) begin
            exe_valid_d    = 1'b0;
        end
    end

    always_comb begin
        sr_d = sr_q;
        if (commit & slot_s_q) begin
            sr_d = bus.alu_status;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.id_valid & ~id_ready & (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // The flush counter reaching 1 marks the last blocked cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    if (flush) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= FLUSH_LOAD;
                    end else if (exe_valid_q & slot_mem & ~bus.mem_ready) begin
                        state_q     <= ST_MEM_WAIT;
                    end else begin
                        state_q     <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q <= 4'd1) begin
                        state_q     <= ST_RUN;
                        flush_cnt_q <= 4'd0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q     <= ST_RUN;
                    flush_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid_q    <= 1'b0;
            exe_cmd_q      <= 4'd0;
            exe_mem_r_en_q <= 1'b0;
            exe_mem_w_en_q <= 1'b0;
            slot_s_q       <= 1'b0;
            slot_b_q       <= 1'b0;
            sr_q           <= 4'd0;
            stall_cnt_q    <= '0;
        end else begin
            exe_valid_q    <= exe_valid_d;
            exe_cmd_q      <= exe_cmd_d;
            exe_mem_r_en_q <= exe_mem_r_en_d;
            exe_mem_w_en_q <= exe_mem_w_en_d;
            slot_s_q       <= slot_s_d;
            slot_b_q       <= slot_b_d;
            sr_q           <= sr_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_exe_issue_ctrl.sv
// tb/tb_exe_issue_ctrl.sv - bench for exe_issue_ctrl: directed steps plus random traffic against a reference model
module tb_exe_issue_ctrl;
    localparam int FLUSH_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_exe_cmd = 4'd0;
    logic       id_mem_r_en = 1'b0;
    logic       id_mem_w_en = 1'b0;
    logic       id_s = 1'b0;
    logic       id_b = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] alu_status = 4'd0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    exe_issue_ctrl_if #(.STALL_CNT_W(16)) ifa ();
    exe_issue_ctrl_if #(.STALL_CNT_W(4))  ifb ();

    assign ifa.id_valid = id_valid;     assign ifb.id_valid = id_valid;
    assign ifa.id_exe_cmd = id_exe_cmd; assign ifb.id_exe_cmd = id_exe_cmd;
    assign ifa.id_mem_r_en = id_mem_r_en; assign ifb.id_mem_r_en = id_mem_r_en;
    assign ifa.id_mem_w_en = id_mem_w_en; assign ifb.id_mem_w_en = id_mem_w_en;
    assign ifa.id_s = id_s;             assign ifb.id_s = id_s;
    assign ifa.id_b = id_b;             assign ifb.id_b = id_b;
    assign ifa.mem_ready = mem_ready;   assign ifb.mem_ready = mem_ready;
    assign ifa.alu_status = alu_status; assign ifb.alu_status = alu_status;

    exe_issue_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .STALL_CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    exe_issue_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .STALL_CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    typedef struct packed {
        logic [3:0] cmd;
        logic       r;
        logic       w;
        logic       s;
        logic       b;
    } instr_t;

    // Reference model: slot contents, remaining blocked cycles, unbounded stall total.
    bit         m_valid;
    instr_t     m_slot;
    logic [3:0] m_sr;
    int         m_block;
    int         m_stall;

    task automatic model_reset();
        m_valid = 1'b0;
        m_slot  = '0;
        m_sr    = 4'd0;
        m_block = 0;
        m_stall = 0;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit v, logic [3:0] cmd, bit r, bit w, bit s, bit b, bit mr, logic [3:0] st);
        id_valid    = v;
        id_exe_cmd  = cmd;
        id_mem_r_en = r;
        id_mem_w_en = w;
        id_s        = s;
        id_b        = b;
        mem_ready   = mr;
        alu_status  = st;
    endtask

    // Entered at a falling edge with inputs already driven; leaves at the next falling edge.
    task automatic step();
        bit e_commit, e_flush, e_ready, e_memreq, slot_mem, blocked;
        int sat_a, sat_b;
        #1;
        slot_mem = m_slot.r | m_slot.w;
        blocked  = (m_block > 0);
        e_commit = m_valid && !blocked && (!slot_mem || mem_ready);
        e_flush  = e_commit && m_slot.b;
        e_ready  = !blocked && !e_flush && (!m_valid || e_commit);
        e_memreq = m_valid && slot_mem && !blocked;
        sat_a    = (m_stall > 65535) ? 65535 : m_stall;
        sat_b    = (m_stall > 15) ? 15 : m_stall;
        check("id_ready",  32'(ifa.id_ready),     32'(e_ready));
        check("commit",    32'(ifa.commit),       32'(e_commit));
        check("flush",     32'(ifa.flush),        32'(e_flush));
        check("mem_req",   32'(ifa.mem_req),      32'(e_memreq));
        check("exe_valid", 32'(ifa.exe_valid),    32'(m_valid));
        if (m_valid) begin
            check("exe_cmd",   32'(ifa.exe_cmd),      32'(m_slot.cmd));
            check("exe_r_en",  32'(ifa.exe_mem_r_en), 32'(m_slot.r));
            check("exe_w_en",  32'(ifa.exe_mem_w_en), 32'(m_slot.w));
        end
        check("sr",        32'(ifa.sr),           32'(m_sr));
        check("stall_a",   32'(ifa.stall_cnt),    32'(sat_a));
        check("stall_b",   32'(ifb.stall_cnt),    32'(sat_b));
        check("ready_b",   32'(ifb.id_ready),     32'(e_ready));
        @(posedge clk);
        if (id_valid && !e_ready) m_stall++;
        if (e_commit && m_slot.s) m_sr = alu_status;
        if (e_flush) m_block = FLUSH_CYCLES;
        else if (m_block > 0) m_block--;
        if (id_valid && e_ready) begin
            m_valid = 1'b1;
            m_slot  = '{cmd: id_exe_cmd, r: id_mem_r_en, w: id_mem_w_en, s: id_s, b: id_b};
        end else if (e_commit || blocked) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        drive(0, 4'd0, 0, 0, 0, 0, 0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_exe_valid", 32'(ifa.exe_valid), 32'd0);
        check("rst_exe_cmd",   32'(ifa.exe_cmd),   32'd0);
        check("rst_sr",        32'(ifa.sr),        32'd0);
        check("rst_mem_req",   32'(ifa.mem_req),   32'd0);
        check("rst_commit",    32'(ifa.commit),    32'd0);
        check("rst_flush",     32'(ifa.flush),     32'd0);
        check("rst_stall",     32'(ifa.stall_cnt), 32'd0);
        rst_n = 1'b1;

        // Back-to-back ALU instructions updating status.
        drive(1, 4'd1, 0, 0, 1, 0, 0, 4'b0000); step();
        drive(1, 4'd2, 0, 0, 1, 0, 0, 4'b1000); step();
        drive(1, 4'd3, 0, 0, 1, 0, 0, 4'b0100); step();
        drive(0, 4'd0, 0, 0, 0, 0, 0, 4'b0010); step();
        drive(0, 4'd0, 0, 0, 0, 0, 0, 4'b1111); step();
        check("b2b_sr",    32'(ifa.sr),        32'b0010);
        check("b2b_stall", 32'(ifa.stall_cnt), 32'd0);

        // Load held for three cycles with the next instruction waiting.
        drive(1, 4'd4, 1, 0, 0, 0, 0, 4'd0); step();
        drive(1, 4'd5, 0, 0, 0, 0, 0, 4'd0);
        repeat (3) step();
        drive(1, 4'd5, 0, 0, 0, 0, 1, 4'd0); step();
        drive(0, 4'd0, 0, 0, 0, 0, 0, 4'd0); step();
        check("load_stall", 32'(ifa.stall_cnt), 32'd3);

        // Taken branch followed by continuous issue attempts.
        drive(1, 4'd6, 0, 0, 0, 1, 0, 4'd0); step();
        drive(1, 4'd7, 0, 0, 0, 0, 1, 4'd0);
        repeat (5) step();
        check("branch_stall", 32'(ifa.stall_cnt), 32'd6);

        // s=0 must leave the status register alone.
        drive(1, 4'd8, 0, 0, 1, 0, 0, 4'd0); step();
        drive(1, 4'd9, 0, 0, 0, 0, 0, 4'b0101); step();
        drive(0, 4'd0, 0, 0, 0, 0, 0, 4'b1111); step();
        check("sr_hold", 32'(ifa.sr), 32'b0101);

        // Asynchronous reset while a store waits on memory.
        drive(1, 4'd10, 0, 1, 0, 0, 0, 4'd0); step();
        drive(0, 4'd0, 0, 0, 0, 0, 0, 4'd0); step();
        check("pre_rst_mem_req", 32'(ifa.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_req",   32'(ifa.mem_req),   32'd0);
        check("arst_exe_valid", 32'(ifa.exe_valid), 32'd0);
        check("arst_sr",        32'(ifa.sr),        32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 4'd0, 0, 0, 0, 0, 0, 4'd0); step();

        // Stall counter saturation on the narrow instance.
        drive(1, 4'd11, 1, 0, 0, 0, 0, 4'd0); step();
        drive(1, 4'd12, 0, 0, 0, 0, 0, 4'd0);
        repeat (20) step();
        check("sat_b", 32'(ifb.stall_cnt), 32'd15);
        check("sat_a", 32'(ifa.stall_cnt), 32'd20);
        drive(0, 4'd0, 0, 0, 0, 0, 1, 4'd0);
        repeat (2) step();

        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 4'($urandom), ($urandom % 5) == 0, ($urandom % 7) == 0,
                  $urandom % 2, ($urandom % 9) == 0, ($urandom % 3) != 0, 4'($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
